// File: rtl/ines_loader.sv
// iNES stream loader: parses the 16-byte header and writes PRG/CHR payload to game memory.
// Optional running payload checksum output is enabled by defining LOADER_CHECKSUM_EN.
module ines_loader #(
    parameter logic [21:0] CHR_BASE      = 22'h200000,
    parameter int unsigned MAX_PRG_BANKS = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  indata,
    input  logic        indata_clk,
    output logic [21:0] mem_addr,
    output logic [7:0]  mem_data,
    output logic        mem_write,
    output logic [31:0] mapper_flags,
    output logic        done,
    output logic        error
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);

    typedef enum logic [2:0] {HEADER, TRAINER, PRG, CHR, DONE, ERROR} state_t;

    state_t      state, state_next;
    logic [21:0] count;
    logic        count_clear;
    logic [7:0]  prg_banks;
    logic [7:0]  chr_banks;
    logic [7:0]  flags6;
    logic [3:0]  flags7_hi;
    logic [7:0]  magic;
    logic [21:0] prg_last;
    logic [21:0] chr_last;
    logic        payload;

    assign prg_last = {prg_banks, 14'd0} - 22'd1;
    assign chr_last = {1'b0, chr_banks, 13'd0} - 22'd1;
    assign payload  = indata_clk && (state == PRG || state == CHR);

    always_comb begin
        magic = 8'h4E;
        case (count[1:0])
            2'd0:    magic = 8'h4E;
            2'd1:    magic = 8'h45;
            2'd2:    magic = 8'h53;
            default: magic = 8'h1A;
        endcase
    end

    always_comb begin
        state_next  = state;
        count_clear = 1'b0;
        if (indata_clk) begin
            case (state)
                HEADER: begin
                    if (count < 22'd4 && indata != magic) begin
                        state_next = ERROR;
                    end else if (count == 22'd15) begin
                        count_clear = 1'b1;
                        if (prg_banks == 8'd0 || 32'(prg_banks) > MAX_PRG_BANKS)
                            state_next = ERROR;
                        else if (flags6[2])
                            state_next = TRAINER;
                        else
                            state_next = PRG;
                    end
                end
                TRAINER: begin
                    if (count == 22'd511) begin
                        count_clear = 1'b1;
                        state_next  = PRG;
                    end
                end
                PRG: begin
                    if (count == prg_last) begin
                        count_clear = 1'b1;
                        state_next  = (chr_banks != 8'd0) ? CHR : DONE;
                    end
                end
                CHR: begin
                    if (count == chr_last) begin
                        count_clear = 1'b1;
                        state_next  = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= HEADER;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= '0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_data     <= '0;
            mapper_flags <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            prg_banks    <= '0;
            chr_banks    <= '0;
            flags6       <= '0;
            flags7_hi    <= '0;
        end else begin
            mem_write <= payload;
            if (payload) begin
                mem_addr <= (state == CHR) ? CHR_BASE + count : count;
                mem_data <= indata;
            end
            if (indata_clk && state != DONE && state != ERROR)
                count <= count_clear ? '0 : count + 22'd1;
            if (indata_clk && state == HEADER) begin
                case (count[3:0])
                    4'd4:    prg_banks <= indata;
                    4'd5:    chr_banks <= indata;
                    4'd6:    flags6    <= indata;
                    4'd7:    flags7_hi <= indata[7:4];
                    default: ;
                endcase
            end
            // Header bytes 4..7 are already latched when byte 15 arrives.
            if (indata_clk && state == HEADER && count == 22'd15 && state_next != ERROR)
                mapper_flags <= {4'd0, chr_banks, prg_banks, chr_banks == 8'd0,
                                 flags6[1], flags6[3], flags6[0], flags7_hi, flags6[7:4]};
            done  <= (state_next == DONE);
            error <= (state_next == ERROR);
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        checksum <= '0;
        else if (payload) checksum <= checksum + {8'd0, indata};
    end
`endif

endmodule

// File: tb/tb_ines_loader.sv
// Self-checking bench for ines_loader: streams iNES images and compares every cycle
// against an image-level reference model.
module tb_ines_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  indata = '0;
    logic        indata_clk = 1'b0;
    logic [21:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_write;
    logic [31:0] mapper_flags;
    logic        done;
    logic        error;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    ines_loader #(.CHR_BASE(22'h200000), .MAX_PRG_BANKS(128)) dut (
        .clk          (clk),
        .reset        (reset),
        .indata       (indata),
        .indata_clk   (indata_clk),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_write    (mem_write),
        .mapper_flags (mapper_flags),
        .done         (done),
        .error        (error)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  img[$];
    int          err_idx;
    int          last_idx;
    int          pay_start;
    int          prg_bytes;
    int          chr_bytes;
    int          writes_seen;
    logic [31:0] exp_flags;
    logic [15:0] exp_sum;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic strobe, input logic [7:0] d);
        @(negedge clk);
        indata_clk = strobe;
        indata     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_write"}, 32'(mem_write), 32'd0);
        check({tag, "_addr"},  32'(mem_addr), 32'd0);
        check({tag, "_data"},  32'(mem_data), 32'd0);
        check({tag, "_flags"}, mapper_flags, 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
`ifdef LOADER_CHECKSUM_EN
        check({tag, "_sum"},   32'(checksum), 32'd0);
`endif
    endtask

    // Asynchronous reset asserted mid-cycle, optionally while a byte is being strobed.
    task automatic do_reset(input logic strobe, input logic [7:0] d);
        @(negedge clk);
        indata_clk = strobe;
        indata     = d;
        #2 reset = 1'b1;
        #1 check_zero("reset_async");
        @(posedge clk);
        #1 check_zero("reset_held");
        @(negedge clk);
        indata_clk = 1'b0;
        reset      = 1'b0;
    endtask

    task automatic make_header(input logic [7:0] b3, input logic [7:0] prg, input logic [7:0] chr,
                               input logic [7:0] f6, input logic [7:0] f7, input bit rnd_tail);
        img.delete();
        img.push_back(8'h4E); img.push_back(8'h45); img.push_back(8'h53); img.push_back(b3);
        img.push_back(prg); img.push_back(chr); img.push_back(f6); img.push_back(f7);
        for (int i = 0; i < 8; i++) img.push_back(rnd_tail ? 8'($urandom) : 8'h00);
    endtask

    // Reference model: derives the whole load outcome from the image bytes.
    task automatic build_expect();
        logic [7:0] m[4];
        logic [7:0] f6, f7, prg, chr;
        m = '{8'h4E, 8'h45, 8'h53, 8'h1A};
        err_idx = -1;
        for (int i = 0; i < 4; i++)
            if (err_idx < 0 && img[i] != m[i]) err_idx = i;
        prg = img[4]; chr = img[5]; f6 = img[6]; f7 = img[7];
        if (err_idx < 0 && (prg == 0 || prg > 128)) err_idx = 15;
        exp_flags = {4'd0, chr, prg, chr == 8'd0, f6[1], f6[3], f6[0], f7[7:4], f6[7:4]};
        pay_start = 16 + (f6[2] ? 512 : 0);
        prg_bytes = int'(prg) * 16384;
        chr_bytes = int'(chr) * 8192;
        last_idx  = pay_start + prg_bytes + chr_bytes - 1;
        writes_seen = 0;
        exp_sum = '0;
    endtask

    function automatic int exp_addr(input int k);
        if (err_idx >= 0) return -1;
        if (k >= pay_start && k < pay_start + prg_bytes) return k - pay_start;
        if (k >= pay_start + prg_bytes && k <= last_idx) return 'h200000 + k - pay_start - prg_bytes;
        return -1;
    endfunction

    // gap_mode: 0 back-to-back, 1 one idle cycle before every byte, 2 random idle cycles.
    task automatic run_image(input int n, input int gap_mode);
        bit st_done = 0;
        bit st_err  = 0;
        int gaps;
        int a;
        for (int k = 0; k < n; k++) begin
            gaps = (gap_mode == 1) ? 1 : (gap_mode == 2 && $urandom_range(0, 3) == 0) ? 1 : 0;
            for (int g = 0; g < gaps; g++) begin
                cycle(1'b0, 8'($urandom));
                check("gap_write", 32'(mem_write), 32'd0);
                check("gap_done",  32'(done), 32'(st_done));
                check("gap_error", 32'(error), 32'(st_err));
            end
            cycle(1'b1, img[k]);
            a = exp_addr(k);
            check("write", 32'(mem_write), 32'(a >= 0));
            if (mem_write) writes_seen++;
            if (a >= 0 && mem_write) begin
                check("addr", 32'(mem_addr), 32'(a));
                check("data", 32'(mem_data), 32'(img[k]));
                exp_sum = exp_sum + 16'(img[k]);
            end
            if (err_idx >= 0 && k >= err_idx) st_err = 1;
            if (err_idx < 0 && k >= last_idx) st_done = 1;
            check("done",  32'(done), 32'(st_done));
            check("error", 32'(error), 32'(st_err));
            if (err_idx < 0 && k == 14) check("flags_pre", mapper_flags, 32'd0);
            if (err_idx < 0 && k == 15) check("flags_hdr", mapper_flags, exp_flags);
`ifdef LOADER_CHECKSUM_EN
            if (err_idx < 0 && k == last_idx) check("sum_at_done", 32'(checksum), 32'(exp_sum));
`endif
        end
        if (n == img.size()) begin
            check("write_count", 32'(writes_seen), (err_idx < 0) ? 32'(prg_bytes + chr_bytes) : 32'd0);
            if (err_idx < 0) check("flags_final", mapper_flags, exp_flags);
`ifdef LOADER_CHECKSUM_EN
            if (err_idx < 0) check("sum_final", 32'(checksum), 32'(exp_sum));
`endif
        end
    endtask

    initial begin
        // 2 PRG / 1 CHR, vertical mirroring, back-to-back strobes
        do_reset(1'b0, 8'h00);
        make_header(8'h1A, 8'd2, 8'd1, 8'h01, 8'h00, 1'b0);
        for (int n = 0; n < 32768; n++) img.push_back(8'(n));
        for (int n = 0; n < 8192; n++) img.push_back(8'($urandom));
        for (int n = 0; n < 8; n++) img.push_back(8'($urandom));
        build_expect();
        run_image(img.size(), 0);

        // Bad magic byte 3
        do_reset(1'b0, 8'h00);
        make_header(8'h1B, 8'd1, 8'd0, 8'h00, 8'h00, 1'b1);
        for (int n = 0; n < 32; n++) img.push_back(8'($urandom));
        build_expect();
        run_image(img.size(), 0);

        // prg_banks at both illegal boundaries
        do_reset(1'b0, 8'h00);
        make_header(8'h1A, 8'd0, 8'd1, 8'h00, 8'h00, 1'b1);
        for (int n = 0; n < 16; n++) img.push_back(8'($urandom));
        build_expect();
        run_image(img.size(), 0);
        do_reset(1'b0, 8'h00);
        make_header(8'h1A, 8'd129, 8'd1, 8'h00, 8'h00, 1'b1);
        for (int n = 0; n < 16; n++) img.push_back(8'($urandom));
        build_expect();
        run_image(img.size(), 0);

        // Gapped strobes, 1 PRG / 0 CHR, random flags and mapper nibbles
        do_reset(1'b0, 8'h00);
        make_header(8'h1A, 8'd1, 8'd0, 8'($urandom) & 8'hFB, 8'($urandom), 1'b1);
        for (int n = 0; n < 16384 + 8; n++) img.push_back(8'($urandom));
        build_expect();
        run_image(4096, 1);
        for (int k = 4096; k < img.size(); k++) begin
            cycle(1'b1, img[k]);
            if (exp_addr(k) >= 0) begin
                check("gp_addr", 32'(mem_addr), 32'(exp_addr(k)));
                check("gp_data", 32'(mem_data), 32'(img[k]));
            end
            check("gp_write", 32'(mem_write), 32'(exp_addr(k) >= 0));
            if (k % 4 == 0) begin
                cycle(1'b0, 8'($urandom));
                check("gp_gap_write", 32'(mem_write), 32'd0);
            end
        end
        check("gp_done", 32'(done), 32'd1);

        // Reset during PRG byte 100, then a trainer image with all-0x01 PRG
        do_reset(1'b0, 8'h00);
        make_header(8'h1A, 8'd1, 8'd0, 8'h00, 8'h00, 1'b1);
        for (int n = 0; n < 200; n++) img.push_back(8'($urandom));
        build_expect();
        run_image(116, 0);
        do_reset(1'b1, img[116]);
        make_header(8'h1A, 8'd1, 8'd0, 8'h04, 8'h00, 1'b1);
        for (int n = 0; n < 512; n++) img.push_back(8'($urandom));
        for (int n = 0; n < 16384; n++) img.push_back(8'h01);
        for (int n = 0; n < 12; n++) img.push_back(8'($urandom));
        build_expect();
        run_image(img.size(), 2);
        check("trainer_chr_ram", 32'(mapper_flags[11]), 32'd1);
        check("trainer_sum_model", 32'(exp_sum), 32'h4000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
